// File: rtl/mem_stage.sv
// mem_stage: EXE/MEM pipeline register, architectural NZCV flags and a Thumb data-memory access unit.
// Latency: non-memory ops reach WB 1 cycle after capture; memops take >= 2 cycles from capture to DONE.
// Backpressure: STALL freezes IF/ID/EXE while an aligned memop waits for DMEM_ACK or for the timeout.
// Ports: EX_* capture inputs and FLUSH; DMEM_* request/acknowledge bus; STALL and LOAD_PENDING to
//        the hazard logic; MEM_DF and NZCV back to execute; WB_* registered write-back; ALIGN_ERR and
//        BUS_ERR one-cycle error pulses.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        EX_VALID,
   input  logic [31:0] EX_RESULT,
   input  logic [3:0]  EX_RD,
   input  logic        EX_VALIDRD,
   input  logic [3:0]  EX_NZCV,
   input  logic        EX_NZCV_WE,
   input  logic [2:0]  EX_MEMOP,
   input  logic        EX_SIGNED,
   input  logic [31:0] EX_STDATA,
   input  logic        FLUSH,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [31:0] DMEM_ADDR,
   output logic [3:0]  DMEM_BE,
   output logic [31:0] DMEM_WDATA,
   input  logic [31:0] DMEM_RDATA,
   input  logic        DMEM_ACK,
   output logic        STALL,
   output logic        LOAD_PENDING,
   output logic [31:0] MEM_DF,
   output logic [3:0]  NZCV,
   output logic [31:0] WB_DATA,
   output logic [3:0]  WB_RD,
   output logic        WB_VALIDRD,
   output logic        ALIGN_ERR,
   output logic        BUS_ERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Counter value of the last ACCESS cycle in which an ACK is still accepted.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;

   logic        stg_vld_q, stg_vld_d;
   logic [31:0] stg_result_q, stg_result_d;
   logic [3:0]  stg_rd_q, stg_rd_d;
   logic        stg_validrd_q, stg_validrd_d;
   logic [2:0]  stg_memop_q, stg_memop_d;
   logic        stg_signed_q, stg_signed_d;
   logic [31:0] stg_stdata_q, stg_stdata_d;

   logic [3:0]  nzcv_q, nzcv_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [3:0]  wb_rd_q, wb_rd_d;
   logic        wb_validrd_q, wb_validrd_d;
   logic        align_err_q, align_err_d;
   logic        bus_err_q, bus_err_d;

   // Decode of the captured memop
   logic        is_load, is_store, is_mem;
   logic        sz_word, sz_half, sz_byte;
   logic        aligned, mem_go, stall;
   logic [1:0]  addr_lo;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] rd_shift;
   logic [31:0] ld_val;

   always_comb begin
      addr_lo  = stg_result_q[1:0];
      is_load  = (stg_memop_q == 3'd1) || (stg_memop_q == 3'd2) || (stg_memop_q == 3'd3);
      is_store = (stg_memop_q == 3'd4) || (stg_memop_q == 3'd5) || (stg_memop_q == 3'd6);
      is_mem   = is_load || is_store;
      sz_word  = (stg_memop_q == 3'd1) || (stg_memop_q == 3'd4);
      sz_half  = (stg_memop_q == 3'd2) || (stg_memop_q == 3'd5);
      sz_byte  = (stg_memop_q == 3'd3) || (stg_memop_q == 3'd6);

      aligned = 1'b1;
      if (sz_word) begin
         aligned = (addr_lo == 2'b00);
      end else if (sz_half) begin
         aligned = ~addr_lo[0];
      end

      mem_go = stg_vld_q && is_mem && aligned;
      // DONE releases the pipe so the next instruction is captured on the way back to IDLE.
      stall  = mem_go && (state_q != DONE);

      be_calc    = 4'b1111;
      wdata_calc = stg_stdata_q;
      if (sz_half) begin
         be_calc    = addr_lo[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{stg_stdata_q[15:0]}};
      end else if (sz_byte) begin
         be_calc    = 4'b0001 << addr_lo;
         wdata_calc = {4{stg_stdata_q[7:0]}};
      end

      // Bring the addressed lane down to bit 0, then extend.
      rd_shift = DMEM_RDATA >> {addr_lo, 3'b000};
      ld_val   = DMEM_RDATA;
      if (sz_half) begin
         ld_val = {{16{stg_signed_q & rd_shift[15]}}, rd_shift[15:0]};
      end else if (sz_byte) begin
         ld_val = {{24{stg_signed_q & rd_shift[7]}}, rd_shift[7:0]};
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = tmo_cnt_q;
      stg_vld_d     = stg_vld_q;
      stg_result_d  = stg_result_q;
      stg_rd_d      = stg_rd_q;
      stg_validrd_d = stg_validrd_q;
      stg_memop_d   = stg_memop_q;
      stg_signed_d  = stg_signed_q;
      stg_stdata_d  = stg_stdata_q;
      nzcv_d        = nzcv_q;
      wb_data_d     = wb_data_q;
      wb_rd_d       = wb_rd_q;
      wb_validrd_d  = 1'b0;
      align_err_d   = 1'b0;
      bus_err_d     = 1'b0;

      if (!stall) begin
         stg_vld_d     = EX_VALID && !FLUSH;
         stg_result_d  = EX_RESULT;
         stg_rd_d      = EX_RD;
         stg_validrd_d = EX_VALIDRD;
         stg_memop_d   = EX_MEMOP;
         stg_signed_d  = EX_SIGNED;
         stg_stdata_d  = EX_STDATA;
         if (EX_NZCV_WE && EX_VALID && !FLUSH) begin
            nzcv_d = EX_NZCV;
         end
      end

      case (state_q)
         IDLE: begin
            if (mem_go) begin
               state_d   = ACCESS;
               tmo_cnt_d = 8'd0;
            end else if (stg_vld_q && is_mem) begin
               // Misaligned: report and retire without touching the bus.
               align_err_d = 1'b1;
            end else if (stg_vld_q) begin
               wb_data_d    = stg_result_q;
               wb_rd_d      = stg_rd_q;
               wb_validrd_d = stg_validrd_q;
            end
         end
         ACCESS: begin
            if (DMEM_ACK) begin
               state_d = DONE;
               if (is_load) begin
                  wb_data_d    = ld_val;
                  wb_rd_d      = stg_rd_q;
                  wb_validrd_d = stg_validrd_q;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = DONE;
               bus_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         tmo_cnt_q     <= 8'd0;
         stg_vld_q     <= 1'b0;
         stg_result_q  <= 32'd0;
         stg_rd_q      <= 4'd0;
         stg_validrd_q <= 1'b0;
         stg_memop_q   <= 3'd0;
         stg_signed_q  <= 1'b0;
         stg_stdata_q  <= 32'd0;
         nzcv_q        <= 4'd0;
         wb_data_q     <= 32'd0;
         wb_rd_q       <= 4'd0;
         wb_validrd_q  <= 1'b0;
         align_err_q   <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         stg_vld_q     <= stg_vld_d;
         stg_result_q  <= stg_result_d;
         stg_rd_q      <= stg_rd_d;
         stg_validrd_q <= stg_validrd_d;
         stg_memop_q   <= stg_memop_d;
         stg_signed_q  <= stg_signed_d;
         stg_stdata_q  <= stg_stdata_d;
         nzcv_q        <= nzcv_d;
         wb_data_q     <= wb_data_d;
         wb_rd_q       <= wb_rd_d;
         wb_validrd_q  <= wb_validrd_d;
         align_err_q   <= align_err_d;
         bus_err_q     <= bus_err_d;
      end
   end

   // REQ/WE/BE come straight from the state flop, so reset drops them without a clock edge.
   assign DMEM_REQ     = (state_q == ACCESS);
   assign DMEM_WE      = DMEM_REQ && is_store;
   assign DMEM_BE      = DMEM_REQ ? be_calc : 4'b0000;
   assign DMEM_ADDR    = {stg_result_q[31:2], 2'b00};
   assign DMEM_WDATA   = wdata_calc;
   assign STALL        = stall;
   assign LOAD_PENDING = stg_vld_q && is_load;
   assign MEM_DF       = stg_result_q;
   assign NZCV         = nzcv_q;
   assign WB_DATA      = wb_data_q;
   assign WB_RD        = wb_rd_q;
   assign WB_VALIDRD   = wb_validrd_q;
   assign ALIGN_ERR    = align_err_q;
   assign BUS_ERR      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a byte-level memory reference model.
// Latency: n/a (testbench).
// Backpressure: the driver holds each instruction until STALL releases; a responder acks with scripted delays.
module tb_mem_stage;
   localparam int TIMEOUT = 15;
   localparam int NO_ACK  = 255;

   logic        CLK, RESET_N;
   logic        EX_VALID, EX_VALIDRD, EX_NZCV_WE, EX_SIGNED, FLUSH;
   logic [31:0] EX_RESULT, EX_STDATA;
   logic [3:0]  EX_RD, EX_NZCV;
   logic [2:0]  EX_MEMOP;
   logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
   logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
   logic [3:0]  DMEM_BE;
   logic        STALL, LOAD_PENDING, WB_VALIDRD, ALIGN_ERR, BUS_ERR;
   logic [31:0] MEM_DF, WB_DATA;
   logic [3:0]  NZCV, WB_RD;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .EX_VALID(EX_VALID), .EX_RESULT(EX_RESULT), .EX_RD(EX_RD), .EX_VALIDRD(EX_VALIDRD),
      .EX_NZCV(EX_NZCV), .EX_NZCV_WE(EX_NZCV_WE), .EX_MEMOP(EX_MEMOP), .EX_SIGNED(EX_SIGNED),
      .EX_STDATA(EX_STDATA), .FLUSH(FLUSH),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
      .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
      .STALL(STALL), .LOAD_PENDING(LOAD_PENDING), .MEM_DF(MEM_DF), .NZCV(NZCV),
      .WB_DATA(WB_DATA), .WB_RD(WB_RD), .WB_VALIDRD(WB_VALIDRD),
      .ALIGN_ERR(ALIGN_ERR), .BUS_ERR(BUS_ERR)
   );

   // kind: 0 = write-back, 1 = alignment error, 2 = bus error
   typedef struct {
      int          kind;
      logic [31:0] data;
      logic [3:0]  rd;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   exp_t        exp_q[$];
   bus_t        bus_q[$];
   int          ack_q[$];
   logic [7:0]  model_mem [0:1023];
   logic [31:0] resp_mem [0:255];
   logic [3:0]  model_nzcv;
   int          n_cmp, n_bad;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int op_size(input logic [2:0] op);
      case (op)
         3'd1, 3'd4: return 4;
         3'd2, 3'd5: return 2;
         3'd3, 3'd6: return 1;
         default:    return 0;
      endcase
   endfunction

   task automatic set_word(input int waddr, input logic [31:0] w);
      resp_mem[waddr] = w;
      for (int j = 0; j < 4; j++) model_mem[waddr*4 + j] = w[8*j +: 8];
   endtask

   // Called at a negedge with STALL low; returns at a negedge with STALL low.
   task automatic issue(input logic [2:0] op, input logic [31:0] res, input logic [3:0] rd,
                        input logic vrd, input logic sgn, input logic [31:0] st,
                        input logic [3:0] nz, input logic nzwe, input logic vld,
                        input logic flush, input int delay);
      int          sz, exp_stall, n;
      bit          live, is_ld;
      logic [31:0] val;
      exp_t        e;
      bus_t        b;
      sz        = op_size(op);
      live      = vld && !flush;
      is_ld     = (op >= 3'd1) && (op <= 3'd3);
      exp_stall = 0;
      EX_VALID = vld; EX_RESULT = res; EX_RD = rd; EX_VALIDRD = vrd; EX_SIGNED = sgn;
      EX_STDATA = st; EX_NZCV = nz; EX_NZCV_WE = nzwe; EX_MEMOP = op; FLUSH = flush;
      if (live && nzwe) model_nzcv = nz;
      if (live) begin
         if (sz == 0) begin
            if (vrd) begin
               e.kind = 0; e.data = res; e.rd = rd;
               exp_q.push_back(e);
            end
         end else if ((res % sz) != 0) begin
            e.kind = 1; e.data = 0; e.rd = 0;
            exp_q.push_back(e);
         end else begin
            b.addr  = res & ~32'd3;
            b.we    = !is_ld;
            b.be    = 4'(((1 << sz) - 1) << (res % 4));
            b.wdata = (sz == 4) ? st :
                      (sz == 2) ? 32'(st[15:0]) * 32'h0001_0001 : 32'(st[7:0]) * 32'h0101_0101;
            bus_q.push_back(b);
            ack_q.push_back(delay);
            if (delay == NO_ACK) begin
               e.kind = 2; e.data = 0; e.rd = 0;
               exp_q.push_back(e);
               exp_stall = TIMEOUT + 1;
            end else begin
               exp_stall = delay + 2;
               if (is_ld) begin
                  val = 0;
                  for (int i = 0; i < sz; i++) val |= 32'(model_mem[res[9:0] + 10'(i)]) << (8*i);
                  if (sgn && sz < 4 && val[8*sz-1]) val |= ~((32'd1 << (8*sz)) - 32'd1);
                  if (vrd) begin
                     e.kind = 0; e.data = val; e.rd = rd;
                     exp_q.push_back(e);
                  end
               end else begin
                  for (int i = 0; i < sz; i++) model_mem[res[9:0] + 10'(i)] = st[8*i +: 8];
               end
            end
         end
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("nzcv", NZCV, model_nzcv);
      chk("mem_df", MEM_DF, res);
      chk("load_pending", LOAD_PENDING, live && is_ld);
      n = 0;
      while (STALL && n < 60) begin
         n++;
         @(negedge CLK);
      end
      chk("stall_cycles", n, exp_stall);
      EX_VALID = 1'b0; FLUSH = 1'b0; EX_NZCV_WE = 1'b0;
   endtask

   // Memory responder: scripted ACK delay per request, random spurious ACKs while idle.
   initial begin
      int          rcnt, rdel;
      bit          active;
      logic [31:0] w;
      active = 0; rcnt = 0; rdel = NO_ACK;
      DMEM_ACK = 1'b0; DMEM_RDATA = 32'd0;
      forever begin
         @(negedge CLK);
         if (!RESET_N) begin
            active = 0; DMEM_ACK = 1'b0;
         end else if (DMEM_REQ) begin
            if (!active) begin
               active = 1; rcnt = 0;
               rdel = (ack_q.size() != 0) ? ack_q.pop_front() : NO_ACK;
            end
            if (rdel != NO_ACK && rcnt == rdel) begin
               w = resp_mem[DMEM_ADDR[9:2]];
               DMEM_RDATA = w;
               if (DMEM_WE)
                  for (int j = 0; j < 4; j++) if (DMEM_BE[j]) w[8*j +: 8] = DMEM_WDATA[8*j +: 8];
               resp_mem[DMEM_ADDR[9:2]] = w;
               DMEM_ACK = 1'b1;
            end else begin
               DMEM_ACK = 1'b0;
               DMEM_RDATA = $urandom;
            end
            rcnt++;
         end else begin
            active = 0;
            DMEM_ACK = ($urandom_range(0, 3) == 0);
            DMEM_RDATA = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event or starts a bus request.
   initial begin
      int   cyc, rise_cyc;
      bit   prev_req;
      bus_t cur, b;
      exp_t e;
      cyc = 0; rise_cyc = 0; prev_req = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RESET_N) begin
            prev_req = 0;
         end else begin
            if (WB_VALIDRD || ALIGN_ERR || BUS_ERR) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_event", {29'd0, BUS_ERR, ALIGN_ERR, WB_VALIDRD}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("event_kind", {29'd0, BUS_ERR, ALIGN_ERR, WB_VALIDRD}, 32'd1 << e.kind);
                  if (e.kind == 0) begin
                     chk("wb_data", WB_DATA, e.data);
                     chk("wb_rd", WB_RD, e.rd);
                  end
                  if (e.kind == 2) begin
                     chk("bus_err_delay", cyc - rise_cyc, TIMEOUT);
                     chk("req_after_bus_err", DMEM_REQ, 0);
                  end
               end
            end
            if (DMEM_REQ && !prev_req) begin
               rise_cyc = cyc;
               cur = '{DMEM_ADDR, DMEM_WE, DMEM_BE, DMEM_WDATA};
               if (bus_q.size() == 0) begin
                  chk("unexpected_req", DMEM_REQ, 0);
               end else begin
                  b = bus_q.pop_front();
                  chk("dmem_addr", DMEM_ADDR, b.addr);
                  chk("dmem_we", DMEM_WE, b.we);
                  chk("dmem_be", DMEM_BE, b.be);
                  if (b.we) chk("dmem_wdata", DMEM_WDATA, b.wdata);
               end
            end else if (DMEM_REQ) begin
               chk("req_stable", {DMEM_ADDR[31:6] ^ cur.addr[31:6], DMEM_ADDR[5:0] ^ cur.addr[5:0]} |
                   (DMEM_WDATA ^ cur.wdata) | {27'd0, DMEM_WE ^ cur.we, DMEM_BE ^ cur.be}, 32'd0);
            end
            prev_req = DMEM_REQ;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] res;
      int          sz, dly;
      n_cmp = 0; n_bad = 0; model_nzcv = 4'd0;
      RESET_N = 1'b0;
      EX_VALID = 0; EX_RESULT = 0; EX_RD = 0; EX_VALIDRD = 0; EX_NZCV = 0; EX_NZCV_WE = 0;
      EX_MEMOP = 0; EX_SIGNED = 0; EX_STDATA = 0; FLUSH = 0;
      for (int i = 0; i < 256; i++) set_word(i, $urandom);
      set_word(32'h100 >> 2, 32'h8001_7FFF);

      #12;
      chk("rst_req", DMEM_REQ, 0);
      chk("rst_stall", STALL, 0);
      chk("rst_wb_validrd", WB_VALIDRD, 0);
      chk("rst_wb_data", WB_DATA, 0);
      chk("rst_nzcv", NZCV, 0);
      chk("rst_align_err", ALIGN_ERR, 0);
      chk("rst_bus_err", BUS_ERR, 0);
      chk("rst_mem_df", MEM_DF, 0);
      chk("rst_load_pending", LOAD_PENDING, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);

      // Directed cases
      issue(3'd0, 32'h1234, 4'd3, 1, 0, 0, 4'd0, 0, 1, 0, 0);               // plain ALU op
      issue(3'd2, 32'h102, 4'd5, 1, 1, 0, 4'd0, 0, 1, 0, 2);                // LDRH signed, ack in 3rd cycle
      issue(3'd6, 32'h203, 4'd0, 0, 0, 32'h55AA_00AB, 4'd0, 0, 1, 0, 0);    // STRB, same-cycle ack
      issue(3'd1, 32'h101, 4'd2, 1, 0, 0, 4'd0, 0, 1, 0, 0);                // misaligned LDR
      issue(3'd1, 32'h80, 4'd6, 1, 0, 0, 4'd0, 0, 1, 0, NO_ACK);            // LDR timeout
      issue(3'd0, 32'hCAFE, 4'd7, 1, 0, 0, 4'd9, 1, 1, 0, 0);               // pipe resumes
      issue(3'd3, 32'h203, 4'd8, 1, 0, 0, 4'd0, 0, 1, 0, 1);                // LDRB reads back 0xAB

      // Reset in the middle of an access
      EX_VALID = 1; EX_MEMOP = 3'd1; EX_RESULT = 32'h40; EX_RD = 4'd1; EX_VALIDRD = 1;
      bus_q.push_back('{32'h40, 1'b0, 4'hF, 32'd0});
      ack_q.push_back(NO_ACK);
      @(posedge CLK);
      @(negedge CLK);
      EX_VALID = 0;
      @(negedge CLK);
      @(negedge CLK);
      chk("req_before_reset", DMEM_REQ, 1);
      #2 RESET_N = 1'b0;
      #1;
      chk("req_async_reset", DMEM_REQ, 0);
      chk("stall_async_reset", STALL, 0);
      exp_q.delete(); bus_q.delete(); ack_q.delete();
      model_nzcv = 4'd0;
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      issue(3'd0, 32'h11, 4'd1, 1, 0, 0, 4'b1010, 1, 1, 1, 0);              // flushed flag write
      chk("nzcv_after_flush", NZCV, 4'b0000);
      issue(3'd0, 32'h22, 4'd2, 1, 0, 0, 4'b0110, 1, 1, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 150; k++) begin
         op  = 3'($urandom_range(0, 7));
         res = 32'($urandom_range(0, 1023));
         sz  = op_size(op);
         if (sz > 1 && $urandom_range(0, 3) != 0) res = res & ~32'(sz - 1);
         dly = ($urandom_range(0, 11) == 0) ? NO_ACK : $urandom_range(0, 4);
         issue(op, res, 4'($urandom), 1'($urandom), 1'($urandom), $urandom, 4'($urandom),
               1'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, dly);
      end

      repeat (4) @(negedge CLK);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("bus_q_drained", 32'(bus_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
